// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: turns an ALU effective address plus funct3 into one
// word-wide memory handshake, with alignment checks and a bounded wait for mem_ready.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_align,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, sdata_q, ld_q, ld_d;
  logic [2:0]        f3_q;
  logic              load_q;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              ea_q, ea_d, et_q, et_d;
  logic              accept, op_legal, op_aligned;
  logic [31:0]       rd_shift, ld_ext;
  logic [15:0]       rd_half;

  assign accept = (state_q == IDLE) && op_valid;

  // Legality and alignment are judged on the raw inputs so the accept edge can
  // route straight to DONE without ever raising mem_req.
  always_comb begin
    op_legal = op_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                       : (funct3 inside {3'b000, 3'b001, 3'b010});
    case (funct3[1:0])
      2'b01:   op_aligned = !addr[0];
      2'b10:   op_aligned = (addr[1:0] == 2'b00);
      default: op_aligned = 1'b1;
    endcase
  end

  assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
  assign rd_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_ext = {16'd0, rd_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    ea_d    = ea_q;
    et_d    = et_q;
    case (state_q)
      IDLE: if (op_valid) begin
        ld_d  = '0;
        et_d  = 1'b0;
        cnt_d = '0;
        if (op_legal && op_aligned) begin
          ea_d    = 1'b0;
          state_d = ACCESS;
        end else begin
          ea_d    = 1'b1;
          state_d = DONE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (load_q) ld_d = ld_ext;
          state_d = DONE;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          et_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= '0;
      ea_q    <= 1'b0;
      et_q    <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      f3_q    <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      ea_q    <= ea_d;
      et_q    <= et_d;
      if (accept) begin
        addr_q  <= addr;
        sdata_q <= store_data;
        f3_q    <= funct3;
        load_q  <= op_load;
      end
    end
  end

  // Memory-side outputs are forced low outside ACCESS so the bus is quiet when idle.
  always_comb begin
    mem_req   = (state_q == ACCESS);
    mem_we    = mem_req && !load_q;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (mem_req) begin
      case (f3_q[1:0])
        2'b00:   mem_wdata = {4{sdata_q[7:0]}};
        2'b01:   mem_wdata = {2{sdata_q[15:0]}};
        default: mem_wdata = sdata_q;
      endcase
      if (!load_q) begin
        case (f3_q[1:0])
          2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
          2'b01:   mem_wstrb = 4'b0011 << addr_q[1:0];
          default: mem_wstrb = 4'b1111;
        endcase
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign load_data   = ld_q;
  assign err_align   = ea_q;
  assign err_timeout = et_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random operations against a
// byte-level reference model and a programmable-latency memory responder.
module tb_load_store_unit;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_load, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_rdata;
  logic        busy, done, err_align, err_timeout, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  // Memory responder: answers after rdy_lat wait cycles of a burst, or never.
  int req_cyc = 0;
  int rdy_lat = 0;
  bit rdy_en = 1'b1;
  bit rdy_force = 1'b0;
  assign mem_ready = rdy_force | (mem_req && rdy_en && (req_cyc == rdy_lat));
  always @(posedge clk) req_cyc <= mem_req ? req_cyc + 1 : 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_load(op_load), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .err_align(err_align), .err_timeout(err_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Reference: access size from funct3, then byte-level lane arithmetic.
  function automatic void model(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd,
                                output bit legal, output logic [3:0] strb,
                                output logic [31:0] wd, output logic [31:0] ldv);
    int sz, off;
    logic [31:0] v;
    sz  = 1 << f3[1:0];
    off = int'(a[1:0]);
    legal = (f3[1:0] != 2'b11) && (ld ? (f3[2] == 1'b0 || sz < 4) : (f3[2] == 1'b0))
            && ((off % sz) == 0);
    strb = 4'(((1 << sz) - 1) << off);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % sz) +: 8];
    v = rd >> (8 * off);
    if (sz < 4) begin
      v = v & ((32'd1 << (8 * sz)) - 32'd1);
      if (!f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    end
    ldv = v;
  endfunction

  task automatic do_op(input string nm, input bit ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int lat, input bit never);
    bit legal;
    logic [3:0] e_strb;
    logic [31:0] e_wd, e_ld, e_data;
    int e_req, e_dcyc, nreq, dcyc;
    logic s_we;
    logic [3:0] s_strb;
    logic [31:0] s_addr, s_wd, s_ld;
    logic s_ea, s_et;
    model(ld, f3, a, sd, rd, legal, e_strb, e_wd, e_ld);
    e_req  = !legal ? 0 : (never ? TMO : lat + 1);
    e_dcyc = !legal ? 1 : (never ? TMO + 1 : lat + 2);
    e_data = (legal && ld && !never) ? e_ld : 32'd0;
    rdy_lat = lat; rdy_en = !never; mem_rdata = rd;
    nreq = 0; dcyc = -1; s_we = 0; s_strb = 0; s_addr = 0; s_wd = 0;
    s_ld = 0; s_ea = 0; s_et = 0;
    @(negedge clk);
    op_valid = 1; op_load = ld; funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    op_valid = 0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_req) begin
        if (nreq == 0) begin s_we = mem_we; s_strb = mem_wstrb; s_addr = mem_addr; s_wd = mem_wdata; end
        nreq++;
      end
      if (done) begin
        dcyc = c; s_ld = load_data; s_ea = err_align; s_et = err_timeout;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (dcyc !== e_dcyc) begin errors++; $display("FAIL %s done_cycle got %0d exp %0d", nm, dcyc, e_dcyc); end
    checks++;
    if (nreq !== e_req) begin errors++; $display("FAIL %s req_cycles got %0d exp %0d", nm, nreq, e_req); end
    checks++;
    if ({s_ea, s_et} !== {!legal, legal && never}) begin
      errors++; $display("FAIL %s err_flags got %b%b exp %b%b", nm, s_ea, s_et, !legal, legal && never);
    end
    checks++;
    if (s_ld !== e_data) begin errors++; $display("FAIL %s load_data got %h exp %h", nm, s_ld, e_data); end
    if (legal) begin
      checks++;
      if (s_addr !== {a[31:2], 2'b00} || s_we !== !ld) begin
        errors++; $display("FAIL %s addr_we got %h/%b exp %h/%b", nm, s_addr, s_we, {a[31:2], 2'b00}, !ld);
      end
      checks++;
      if (s_strb !== (ld ? 4'b0000 : e_strb)) begin
        errors++; $display("FAIL %s wstrb got %b exp %b", nm, s_strb, ld ? 4'b0000 : e_strb);
      end
      if (!ld) begin
        checks++;
        if (s_wd !== e_wd) begin errors++; $display("FAIL %s wdata got %h exp %h", nm, s_wd, e_wd); end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || load_data !== e_data) begin
      errors++; $display("FAIL %s hold got done=%b busy=%b ld=%h exp 0/0/%h", nm, done, busy, load_data, e_data);
    end
  endtask

  task automatic test_reset();
    rst = 1; op_valid = 0; op_load = 0; funct3 = 0; addr = 0; store_data = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, load_data, err_align, err_timeout, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset outputs got nonzero busy=%b done=%b req=%b", busy, done, mem_req);
    end
    rst = 0;
  endtask

  task automatic test_directed();
    do_op("lw", 1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0);
    do_op("lb_103", 1, 3'b000, 32'h103, 0, 32'h80FF1234, 0, 0);
    do_op("lbu_103", 1, 3'b100, 32'h103, 0, 32'h80FF1234, 1, 0);
    do_op("lh_102", 1, 3'b001, 32'h102, 0, 32'h80FF1234, 0, 0);
    do_op("lhu_102", 1, 3'b101, 32'h102, 0, 32'h80FF1234, 2, 0);
    do_op("lb_100", 1, 3'b000, 32'h100, 0, 32'h80FF1234, 0, 0);
    do_op("sb_101", 0, 3'b000, 32'h101, 32'h000000A5, 0, 0, 0);
    do_op("sh_102", 0, 3'b001, 32'h102, 32'h00001234, 0, 0, 0);
    do_op("lw_mis", 1, 3'b010, 32'h102, 0, 32'hFFFFFFFF, 0, 0);
    do_op("sh_mis", 0, 3'b001, 32'h101, 32'h1234, 0, 0, 0);
    do_op("ld_f3_011", 1, 3'b011, 32'h100, 0, 32'hFFFFFFFF, 0, 0);
  endtask

  task automatic test_timeout();
    do_op("timeout_lw", 1, 3'b010, 32'h200, 0, 32'h12345678, 0, 1);
    do_op("timeout_sw", 0, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, 1);
  endtask

  task automatic test_reset_midwait();
    int ndone;
    rdy_en = 0; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    op_valid = 1; op_load = 1; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    op_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({busy, done, load_data, err_align, err_timeout, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== '0) begin
      errors++; $display("FAIL rst_midwait outputs got busy=%b req=%b done=%b", busy, mem_req, done);
    end
    @(negedge clk);
    rdy_force = 1;
    @(negedge clk);
    rdy_force = 0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || mem_req || busy) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL rst_late_resp activity got %0d exp 0", ndone); end
    rdy_en = 1;
  endtask

  task automatic test_busy_ignore();
    int bursts, ndone;
    logic prev_req;
    rdy_lat = 3; rdy_en = 1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    op_valid = 1; op_load = 1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    op_valid = 0;
    bursts = 0; ndone = 0; prev_req = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin op_valid = 1; addr = 32'h500; end
      if (c == 3) op_valid = 0;
      if (mem_req && !prev_req) bursts++;
      prev_req = mem_req;
      if (done) ndone++;
      @(negedge clk);
    end
    checks++;
    if (bursts !== 1 || ndone !== 1) begin
      errors++; $display("FAIL busy_ignore got bursts=%0d dones=%0d exp 1/1", bursts, ndone);
    end
    checks++;
    if (load_data !== 32'h0BADF00D) begin errors++; $display("FAIL busy_ignore load_data got %h exp 0badf00d", load_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_midwait();
    test_busy_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle load/store stage directly downstream of the ALU in the unpipelined RISC-V core. It takes the ALU result as the effective address, plus rs2 and funct3. It drives a word-wide data-memory request/ready handshake with byte strobes, and returns sign- or zero-extended load data to writeback. Misaligned or undefined accesses and a non-responding memory are reported as error flags instead of hanging the core.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req is held without mem_ready before abort (>=1)
TO_W, 5, width of the timeout counter (must hold TIMEOUT_CYCLES-1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
op_valid  input  1  start request; accepted only in IDLE
op_load  input  1  1 = load, 0 = store
funct3  input  3  RV32I width/sign code
addr  input  32  effective address (ALU result)
store_data  input  32  rs2 value for stores
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result, valid while done=1
err_align  output  1  misaligned or undefined funct3, valid with done
err_timeout  output  1  memory did not respond, valid with done
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wstrb  output  4  byte write enables (0000 for loads)
mem_wdata  output  32  lane-replicated write data
mem_ready  input  1  memory accepts/returns in this cycle
mem_rdata  input  32  read word, valid when mem_ready=1

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE. Every output is 0, including load_data, the error flags, and all mem_* signals.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On op_valid=1, register addr, funct3, op_load and store_data.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Legal and aligned -> ACCESS with timeout counter cleared. Otherwise -> DONE with err_align=1 and no memory request.
  - op_valid while busy is ignored; it is not queued.
- ACCESS:
  - mem_req=1; mem_we = !op_load; mem_addr, mem_wstrb and mem_wdata are decoded from the registered operands.
  - Strobes: SB = 0001<<addr[1:0]; SH = 0011<<addr[1:0]; SW = 1111.
  - Write data: SB = byte replicated x4; SH = half replicated x2; SW unchanged.
  - mem_ready is sampled in the same cycle as mem_req; combinational ready is allowed, so minimum ACCESS time is 1 cycle.
  - mem_ready=1: capture the extracted load data (loads), go to DONE.
  - mem_ready=0 and count == TIMEOUT_CYCLES-1: go to DONE with err_timeout=1. Otherwise increment count. mem_req is therefore held at most TIMEOUT_CYCLES cycles.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - load_data = 0 for stores and for any error.
- DONE: done=1 for exactly one cycle, then IDLE. load_data and error flags hold their values until the next accept, then clear.
- Latency from the op_valid accept edge:
  - Aligned access, ready in first ACCESS cycle: done asserted in cycle 2.
  - Align error: done in cycle 1.
  - Timeout: done in cycle TIMEOUT_CYCLES+1.
- mem_ready outside ACCESS is ignored.
- rst in any state (including mid-wait): IDLE at the next edge, mem_req drops. Any late response is ignored; no done is issued for the aborted operation.
- err_align and err_timeout are never both set.

Test Plan:
- LW addr=0x100, mem_ready=1 in first ACCESS cycle, rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, mem_wstrb=0000, done 2 cycles after accept, load_data=0xDEADBEEF.
- rdata=0x80FF1234:
  - LB at 0x103 -> 0xFFFFFF80; LBU at 0x103 -> 0x00000080.
  - LH at 0x102 -> 0xFFFF80FF; LHU at 0x102 -> 0x000080FF.
  - LB at 0x100 -> 0x00000034.
- SB at 0x101, store_data=0x000000A5 -> wstrb=0010, wdata=0xA5A5A5A5, mem_we=1. SH at 0x102, data=0x00001234 -> wstrb=1100, wdata=0x12341234.
- LW at 0x102, and SH at 0x101 -> mem_req never asserted, done 1 cycle after accept, err_align=1, load_data=0. funct3=011 load -> same response.
- mem_ready held 0 (TIMEOUT_CYCLES=16) -> mem_req high exactly 16 cycles, then done with err_timeout=1, load_data=0.
- rst asserted in 3rd ACCESS wait cycle, mem_ready pulsed 2 cycles later -> all outputs 0 after rst edge, no done. op_valid pulsed during a busy LW -> ignored, only one mem_req burst.
